dbg_run_ctrl: RTL and testbench
===============================

# dbg_run_ctrl

Debug run-control sequencer for the 3-stage RV32I core. It accepts halt, resume and single-step commands from the external debugger and detects `ebreak` in decode. It sequences the fetch stage and IF/ID/ID-EX registers so the core parks cleanly with the pipeline filled by NOPs, and it records the debug PC and halt cause. It sits between the debug transport and the core's fetch/decode stages, alongside the decoder.

## Interface
- `DRAIN_CYCLES`, default 2: cycles needed to retire in-flight instructions after fetch is frozen.
- `NOP_INSTR`, default 32'h00000013: canonical NOP (`addi x0,x0,0`), exported for the IF/ID mux.
- `clk` in 1: core clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `dbg_halt_req` in 1: level; request a halt.
- `dbg_resume_req` in 1: level; resume from the halted state.
- `dbg_step_req` in 1: level; execute one instruction, then halt again.
- `ebreak_hit` in 1: the instruction in ID is `ebreak`.
- `id_pc` in 32: PC of the instruction in ID.
- `pc_if` in 32: current fetch PC; already includes any redirect from stage 3.
- `fetch_stall` out 1: hold the PC register. A stage-3 redirect still updates the PC.
- `inject_nop` out 1: IF/ID loads NOP_INSTR instead of the fetched word.
- `squash_id` out 1: ID/EX loads NOP (combinational).
- `dbg_halted` out 1: the core is parked.
- `dbg_ack` out 1: one-cycle pulse when a command is accepted.
- `dpc` out 32: debug PC, i.e. the next instruction to execute on resume.
- `dcause` out 2: halt cause. 00 reset/none, 01 halt request, 10 ebreak, 11 step.

## Operation
- FSM states: RUN, DRAIN, HALTED, STEP_ISSUE, STEP_WAIT.
- **RUN:** `fetch_stall`=0, `inject_nop`=0.
  - `ebreak_hit` → `squash_id`=1 that cycle, `dpc`←`id_pc`, `dcause`←10, go to DRAIN.
  - Otherwise `dbg_halt_req` → `dcause`←01, go to DRAIN, `dbg_ack`=1.
  - `ebreak_hit` has priority over `dbg_halt_req`.
- **DRAIN:** `fetch_stall`=1, `inject_nop`=1. The drain counter loads DRAIN_CYCLES-1 on entry and decrements each cycle. At 0:
  - `dpc`←`pc_if`, unless the cause is ebreak (the ebreak's `dpc` is kept).
  - Go to HALTED.
- **HALTED:** `fetch_stall`=1, `inject_nop`=1, `dbg_halted`=1.
  - `dbg_resume_req` → RUN with `dbg_ack`=1.
  - Otherwise `dbg_step_req` → STEP_ISSUE with `dbg_ack`=1.
  - Resume beats step when both are asserted.
  - `dbg_halt_req` is ignored.
- **STEP_ISSUE (1 cycle):** `fetch_stall`=0, `inject_nop`=0, so exactly one instruction at `pc_if` enters IF/ID. Go to STEP_WAIT.
- **STEP_WAIT:** `fetch_stall`=1, `inject_nop`=1. Counts DRAIN_CYCLES+1 cycles, then `dpc`←`pc_if`, `dcause`←11, go to HALTED.
  - `ebreak_hit` during the wait → `squash_id`, `dpc`←`id_pc`, `dcause`←10, and still go to HALTED at count end.
- Command inputs are levels. A command is accepted only in a state that can act on it. A held request re-fires only after the state changes back. The debugger deasserts a request after seeing `dbg_ack`.
- `dpc` and `dcause` are held while in RUN until the next halt.

## Timing
- Reset values: state RUN, `fetch_stall`=0, `inject_nop`=0, `dbg_halted`=0, `dbg_ack`=0, `dpc`=0, `dcause`=00, counter=0.
- `dbg_halt_req` in RUN at cycle N:
  - `fetch_stall`/`inject_nop` = 1 from N+1.
  - `dbg_halted` = 1 at N+1+DRAIN_CYCLES.
- `dbg_resume_req` in HALTED at cycle N: `fetch_stall`=0 at N+1.
- Step latency, request to `dbg_halted`=1 again: DRAIN_CYCLES+3 cycles.
- Reset asserted mid-DRAIN or mid-step: immediate return to reset values; no partial `dpc` update.
- All outputs are registered, except `squash_id`, which is combinational from `ebreak_hit` and the current state.

## Configuration
- `DBG_HALT_ON_RESET_EN` defined:
  - Reset state is HALTED: `dbg_halted`=1, `fetch_stall`=1, `inject_nop`=1, `dcause`=00, `dpc`=0.
  - The core executes nothing until `dbg_resume_req` or `dbg_step_req`.
- Undefined: reset state is RUN, as above.

## Structure
- Package `dbg_pkg`:
  - `run_state_t` enum.
  - `dcause` constants `CAUSE_NONE`/`CAUSE_HALT`/`CAUSE_EBREAK`/`CAUSE_STEP`.
  - `NOP_INSTR`.
- One sub-module, `dbg_drain_counter`: loadable down-counter with a `done` flag, shared by DRAIN and STEP_WAIT.

## Test plan
- Halt with `DRAIN_CYCLES`=2, `pc_if`=0x40: pulse `dbg_halt_req` at cycle 10 → `fetch_stall`=1 at cycle 11, `dbg_halted`=1 at cycle 13, `dpc`=0x40, `dcause`=01, one `dbg_ack` pulse.
- `ebreak_hit` with `id_pc`=0x1C, coincident with `dbg_halt_req` → `squash_id`=1 that cycle, `dcause`=10, `dpc`=0x1C.
- Step from halted, `pc_if` advancing 0x20→0x24 → exactly one non-NOP instruction enters IF/ID, halted again after 5 cycles, `dpc`=0x24, `dcause`=11.
- `dbg_resume_req` and `dbg_step_req` both asserted while halted → RUN next cycle, `fetch_stall`=0, no step.
- `rst_n` low during STEP_WAIT → all outputs at reset values on the next edge, `dpc` unchanged from 0. Repeat with `DBG_HALT_ON_RESET_EN` defined → `dbg_halted`=1 out of reset.
- `dbg_halt_req` held high in RUN for 10 cycles → exactly one `dbg_ack`, and no re-entry to DRAIN while halted.

Source files
------------

// File: rtl/dbg_pkg.sv
// Shared types and constants for the debug run-control sequencer.
package dbg_pkg;

  typedef enum logic [2:0] {
    RUN,
    DRAIN,
    HALTED,
    STEP_ISSUE,
    STEP_WAIT
  } run_state_t;

  localparam logic [1:0] CAUSE_NONE   = 2'b00;
  localparam logic [1:0] CAUSE_HALT   = 2'b01;
  localparam logic [1:0] CAUSE_EBREAK = 2'b10;
  localparam logic [1:0] CAUSE_STEP   = 2'b11;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/dbg_drain_counter.sv
// Loadable down-counter that saturates at zero; done is high while the count is zero.
module dbg_drain_counter #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/dbg_run_ctrl.sv
// Debug run-control sequencer: halt/resume/step/ebreak handling with pipeline drain.
// Define DBG_HALT_ON_RESET_EN to come out of reset parked in HALTED.
module dbg_run_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter logic [31:0] NOP_INSTR    = dbg_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dbg_halt_req,
  input  logic        dbg_resume_req,
  input  logic        dbg_step_req,
  input  logic        ebreak_hit,
  input  logic [31:0] id_pc,
  input  logic [31:0] pc_if,
  output logic        fetch_stall,
  output logic        inject_nop,
  output logic        squash_id,
  output logic        dbg_halted,
  output logic        dbg_ack,
  output logic [31:0] dpc,
  output logic [1:0]  dcause
);

  import dbg_pkg::*;

  localparam int unsigned CW = $clog2(DRAIN_CYCLES + 2);

`ifdef DBG_HALT_ON_RESET_EN
  localparam run_state_t RST_STATE = HALTED;
  localparam logic       RST_PARK  = 1'b1;
`else
  localparam run_state_t RST_STATE = RUN;
  localparam logic       RST_PARK  = 1'b0;
`endif

  // The IF/ID mux uses NOP_INSTR directly; it must be an OP-IMM that writes x0.
  if (NOP_INSTR[6:0] != 7'b0010011 || NOP_INSTR[11:7] != 5'd0) begin : g_bad_nop
    $error("NOP_INSTR must be an OP-IMM instruction writing x0");
  end
  if (DRAIN_CYCLES < 1) begin : g_bad_drain
    $error("DRAIN_CYCLES must be at least 1");
  end

  run_state_t    state_q, state_d;
  logic          cnt_load;
  logic [CW-1:0] cnt_load_val;
  logic          cnt_done;

  // keep_q marks a dpc already captured from an ebreak, so the drain end must not overwrite it.
  logic          keep_q, keep_d;
  logic          stall_d, inject_d, halted_d, ack_d;
  logic [31:0]   dpc_d;
  logic [1:0]    dcause_d;

  dbg_drain_counter #(
    .WIDTH (CW)
  ) u_drain_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .done     (cnt_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RST_STATE;
      fetch_stall <= RST_PARK;
      inject_nop  <= RST_PARK;
      dbg_halted  <= RST_PARK;
      dbg_ack     <= 1'b0;
      dpc         <= '0;
      dcause      <= CAUSE_NONE;
      keep_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_stall <= stall_d;
      inject_nop  <= inject_d;
      dbg_halted  <= halted_d;
      dbg_ack     <= ack_d;
      dpc         <= dpc_d;
      dcause      <= dcause_d;
      keep_q      <= keep_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = CW'(DRAIN_CYCLES - 1);
    unique case (state_q)
      RUN: begin
        if (ebreak_hit || dbg_halt_req) begin
          state_d  = DRAIN;
          cnt_load = 1'b1;
        end
      end
      DRAIN:      if (cnt_done) state_d = HALTED;
      HALTED: begin
        if (dbg_resume_req)    state_d = RUN;
        else if (dbg_step_req) state_d = STEP_ISSUE;
      end
      STEP_ISSUE: begin
        state_d      = STEP_WAIT;
        cnt_load     = 1'b1;
        cnt_load_val = CW'(DRAIN_CYCLES);
      end
      STEP_WAIT:  if (cnt_done) state_d = HALTED;
      default:    state_d = RUN;
    endcase
  end

  always_comb begin
    dpc_d    = dpc;
    dcause_d = dcause;
    keep_d   = keep_q;
    ack_d    = 1'b0;
    unique case (state_q)
      RUN: begin
        if (ebreak_hit) begin
          dpc_d    = id_pc;
          dcause_d = CAUSE_EBREAK;
          keep_d   = 1'b1;
        end else if (dbg_halt_req) begin
          dcause_d = CAUSE_HALT;
          ack_d    = 1'b1;
          keep_d   = 1'b0;
        end
      end
      DRAIN: begin
        if (cnt_done) begin
          if (!keep_q) dpc_d = pc_if;
          keep_d = 1'b0;
        end
      end
      HALTED:     ack_d = dbg_resume_req || dbg_step_req;
      STEP_ISSUE: keep_d = 1'b0;
      STEP_WAIT: begin
        if (ebreak_hit) begin
          dpc_d    = id_pc;
          dcause_d = CAUSE_EBREAK;
          keep_d   = 1'b1;
        end else if (cnt_done && !keep_q) begin
          dpc_d    = pc_if;
          dcause_d = CAUSE_STEP;
        end
        if (cnt_done) keep_d = 1'b0;
      end
      default: ;
    endcase
    stall_d  = !(state_d inside {RUN, STEP_ISSUE});
    inject_d = stall_d;
    halted_d = (state_d == HALTED);
  end

  assign squash_id = ebreak_hit && (state_q == RUN || state_q == STEP_WAIT);

endmodule

// File: tb/tb_dbg_run_ctrl.sv
// Directed, table-driven bench for dbg_run_ctrl (DRAIN_CYCLES = 2).
module tb_dbg_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dbg_halt_req, dbg_resume_req, dbg_step_req, ebreak_hit;
  logic [31:0] id_pc, pc_if;
  logic        fetch_stall, inject_nop, squash_id, dbg_halted, dbg_ack;
  logic [31:0] dpc;
  logic [1:0]  dcause;

  int checks = 0;
  int errors = 0;

`ifdef DBG_HALT_ON_RESET_EN
  localparam logic RST_PARK = 1'b1;
`else
  localparam logic RST_PARK = 1'b0;
`endif

  dbg_run_ctrl #(
    .DRAIN_CYCLES (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .dbg_halt_req   (dbg_halt_req),
    .dbg_resume_req (dbg_resume_req),
    .dbg_step_req   (dbg_step_req),
    .ebreak_hit     (ebreak_hit),
    .id_pc          (id_pc),
    .pc_if          (pc_if),
    .fetch_stall    (fetch_stall),
    .inject_nop     (inject_nop),
    .squash_id      (squash_id),
    .dbg_halted     (dbg_halted),
    .dbg_ack        (dbg_ack),
    .dpc            (dpc),
    .dcause         (dcause)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        halt, resume, step, ebreak;
    logic [31:0] id_pc, pc_if;
    logic        e_squash, e_stall, e_inj, e_halted, e_ack;
    logic [31:0] e_dpc;
    logic [1:0]  e_cause;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".fetch_stall"}, 32'(fetch_stall), 32'(RST_PARK));
    chk({tag, ".inject_nop"},  32'(inject_nop),  32'(RST_PARK));
    chk({tag, ".dbg_halted"},  32'(dbg_halted),  32'(RST_PARK));
    chk({tag, ".dbg_ack"},     32'(dbg_ack),     32'd0);
    chk({tag, ".dpc"},         dpc,              32'd0);
    chk({tag, ".dcause"},      32'(dcause),      32'd0);
  endtask

  initial begin
    int acks;
    int relapse;
    int budget;
    logic seen_halt;

    //          halt resume step ebreak id_pc   pc_if  | sq stall inj hlt ack dpc   cause
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 2'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 32'h40, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h00, 2'd1};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 32'h40, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 2'd1};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 32'h40, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 2'd1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 32'h40, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 2'd1};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h00, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 2'd1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h1C, 32'h40, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1C, 2'd2};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 32'h50, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1C, 2'd2};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 32'h50, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1C, 2'd2};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h30, 32'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1C, 2'd2};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 32'h20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1C, 2'd2};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 32'h24, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1C, 2'd2};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 32'h24, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1C, 2'd2};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 32'h24, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h24, 2'd3};

    rst_n = 1'b0;
    dbg_halt_req = 1'b0; dbg_resume_req = 1'b0; dbg_step_req = 1'b0; ebreak_hit = 1'b0;
    id_pc = '0; pc_if = 32'h40;
    tick();
    tick();
    chk_reset_vals("in_reset");
    rst_n = 1'b1;
    tick();
    chk_reset_vals("after_reset");

`ifdef DBG_HALT_ON_RESET_EN
    dbg_resume_req = 1'b1;
    tick();
    dbg_resume_req = 1'b0;
    chk("hor_resume.fetch_stall", 32'(fetch_stall), 32'd0);
    chk("hor_resume.ack", 32'(dbg_ack), 32'd1);
`endif

    for (int i = 0; i < 14; i++) begin
      dbg_halt_req   = tbl[i].halt;
      dbg_resume_req = tbl[i].resume;
      dbg_step_req   = tbl[i].step;
      ebreak_hit     = tbl[i].ebreak;
      id_pc          = tbl[i].id_pc;
      pc_if          = tbl[i].pc_if;
      #1;
      chk($sformatf("row%0d.squash_id", i), 32'(squash_id), 32'(tbl[i].e_squash));
      tick();
      chk($sformatf("row%0d.fetch_stall", i), 32'(fetch_stall), 32'(tbl[i].e_stall));
      chk($sformatf("row%0d.inject_nop", i),  32'(inject_nop),  32'(tbl[i].e_inj));
      chk($sformatf("row%0d.dbg_halted", i),  32'(dbg_halted),  32'(tbl[i].e_halted));
      chk($sformatf("row%0d.dbg_ack", i),     32'(dbg_ack),     32'(tbl[i].e_ack));
      chk($sformatf("row%0d.dpc", i),         dpc,              tbl[i].e_dpc);
      chk($sformatf("row%0d.dcause", i),      32'(dcause),      32'(tbl[i].e_cause));
    end
    dbg_halt_req = 1'b0; dbg_resume_req = 1'b0; dbg_step_req = 1'b0; ebreak_hit = 1'b0;

    // ebreak inside the step window overrides the step's dpc/cause
    dbg_step_req = 1'b1;
    tick();
    dbg_step_req = 1'b0;
    chk("stepbrk.ack", 32'(dbg_ack), 32'd1);
    tick();
    ebreak_hit = 1'b1; id_pc = 32'h88; pc_if = 32'h99;
    #1;
    chk("stepbrk.squash_id", 32'(squash_id), 32'd1);
    tick();
    ebreak_hit = 1'b0;
    chk("stepbrk.dpc_early", dpc, 32'h88);
    budget = 0;
    while (!dbg_halted && budget < 8) begin
      tick();
      budget++;
    end
    chk("stepbrk.halted", 32'(dbg_halted), 32'd1);
    chk("stepbrk.dpc", dpc, 32'h88);
    chk("stepbrk.dcause", 32'(dcause), 32'd2);

    // held halt request: one ack, no second drain once parked
    dbg_resume_req = 1'b1;
    tick();
    dbg_resume_req = 1'b0;
    chk("held.resume_stall", 32'(fetch_stall), 32'd0);
    acks = 0; relapse = 0; seen_halt = 1'b0;
    dbg_halt_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (dbg_ack) acks++;
      if (dbg_halted) seen_halt = 1'b1;
      else if (seen_halt) relapse++;
    end
    dbg_halt_req = 1'b0;
    chk("held.ack_count", 32'(acks), 32'd1);
    chk("held.halted", 32'(dbg_halted), 32'd1);
    chk("held.relapse", 32'(relapse), 32'd0);
    chk("held.dcause", 32'(dcause), 32'd1);

    // reset in the middle of STEP_WAIT
    dbg_step_req = 1'b1;
    tick();
    dbg_step_req = 1'b0;
    tick();
    tick();
    chk("rststep.in_wait", 32'(fetch_stall), 32'd1);
    rst_n = 1'b0;
    tick();
    chk_reset_vals("rststep");
    rst_n = 1'b1;
    tick();
    tick();
    chk_reset_vals("rststep_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
